// File: rtl/relu_maxpool.sv
// relu_maxpool: 2x2 stride-2 max pooling with ReLU over a channel-major int8 feature map held in BRAM
module relu_maxpool #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 32,
  parameter int HEIGHT     = 28,
  parameter int WIDTH      = 32,
  parameter int IN_ADDR_W  = 15,
  parameter int OUT_ADDR_W = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [IN_ADDR_W-1:0]         rd_addr,
  input  logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         wr_en,
  output logic [OUT_ADDR_W-1:0]        wr_addr,
  output logic signed [DATA_WIDTH-1:0] wr_data
);
  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, LAST, WR, DONE} state_t;
  localparam int TOTAL = CHANNELS * HEIGHT * WIDTH / 4;
  localparam int CW = $clog2(CHANNELS + 1);
  localparam int RW = $clog2(HEIGHT / 2 + 1);
  localparam int OW = $clog2(WIDTH / 2 + 1);
  state_t r_state, w_next;
  logic [1:0] r_rs;
  logic [CW-1:0] r_ch;
  logic [RW-1:0] r_orow;
  logic [OW-1:0] r_ocol;
  logic [OUT_ADDR_W-1:0] r_out_addr, r_wr_addr;
  logic [IN_ADDR_W-1:0] r_base, w_base_n, r_rd_addr, w_rd_addr_n;
  logic signed [DATA_WIDTH-1:0] r_acc, w_acc_n;
  logic r_busy, r_done, r_rd_en, r_wr_en;
  logic w_go, w_col_wrap, w_row_wrap, w_last, w_tap;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_rs <= 2'b11;
    else     r_rs <= {r_rs[0], 1'b0};
  always_comb begin
    w_go       = start & ~r_rs[1];
    w_col_wrap = r_ocol == OW'(WIDTH / 2 - 1);
    w_row_wrap = r_orow == RW'(HEIGHT / 2 - 1);
    w_last     = w_col_wrap && w_row_wrap && r_ch == CW'(CHANNELS - 1);
    w_tap      = r_state inside {RD1, RD2, RD3, LAST};
    w_next     = (r_state == IDLE || r_state == DONE) ? (w_go ? RD0 : r_state) :
                 (r_state == WR) ? (w_last ? DONE : RD0) : state_t'(r_state + 3'd1);
    // Advancing the column by one window is +2; finishing a row pair (or a channel) is +2+WIDTH.
    w_base_n   = (r_state != WR) ? r_base : w_last ? '0 :
                 r_base + IN_ADDR_W'(2) + (w_col_wrap ? IN_ADDR_W'(WIDTH) : '0);
    w_rd_addr_n = (w_next == RD0) ? w_base_n :
                  (w_next == RD1) ? r_base + IN_ADDR_W'(1) :
                  (w_next == RD2) ? r_base + IN_ADDR_W'(WIDTH) :
                  (w_next == RD3) ? r_base + IN_ADDR_W'(WIDTH + 1) : '0;
    w_acc_n    = (w_next == RD0) ? '0 : (w_tap && rd_data > r_acc) ? rd_data : r_acc;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= IDLE;
      r_ch       <= '0;
      r_orow     <= '0;
      r_ocol     <= '0;
      r_out_addr <= '0;
      r_base     <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
    end else begin
      r_state   <= w_next;
      r_base    <= w_base_n;
      r_acc     <= w_acc_n;
      r_busy    <= w_next != IDLE && w_next != DONE;
      r_done    <= w_next == DONE;
      r_rd_en   <= w_next inside {RD0, RD1, RD2, RD3};
      r_rd_addr <= w_rd_addr_n;
      r_wr_en   <= w_next == WR;
      r_wr_addr <= (w_next == WR) ? r_out_addr : r_wr_addr;
      if (r_state == WR) begin
        r_out_addr <= w_last ? '0 : r_out_addr + 1'b1;
        r_ocol     <= w_col_wrap ? '0 : r_ocol + 1'b1;
        r_orow     <= w_col_wrap ? (w_row_wrap ? '0 : r_orow + 1'b1) : r_orow;
        r_ch       <= (w_col_wrap && w_row_wrap) ? (w_last ? '0 : r_ch + 1'b1) : r_ch;
      end
    end
endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: single-window vector table and randomized windows on a 1x2x2 instance, full-map sweep with aborts on the default instance
module tb_relu_maxpool;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic s_start = 1'b0, s_busy, s_done, s_rd_en, s_wr_en;
  logic [1:0] s_rd_addr, s_wr_addr;
  logic signed [7:0] s_rd_data = '0, s_wr_data;
  logic signed [7:0] mem_s [4];
  relu_maxpool #(.DATA_WIDTH(8), .CHANNELS(1), .HEIGHT(2), .WIDTH(2), .IN_ADDR_W(2), .OUT_ADDR_W(2)) u_s (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data));
  always @(posedge clk) if (s_rd_en) s_rd_data <= mem_s[s_rd_addr];

  logic d_start = 1'b0, d_busy, d_done, d_rd_en, d_wr_en;
  logic [14:0] d_rd_addr;
  logic [12:0] d_wr_addr;
  logic signed [7:0] d_rd_data = '0, d_wr_data;
  logic signed [7:0] mem_d [32768];
  relu_maxpool u_d (
    .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .done(d_done),
    .rd_en(d_rd_en), .rd_addr(d_rd_addr), .rd_data(d_rd_data),
    .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data));
  always @(posedge clk) if (d_rd_en) d_rd_data <= mem_d[d_rd_addr];

  int cmp = 0, bad = 0;
  int wa[$], wd[$], ra[$];
  int dcyc, ovl;

  typedef struct {logic signed [7:0] a, b, c, d; int exp;} vec_t;
  vec_t tv[3];

  task automatic check(input string nm, input int act, input int exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int relu_max4(input int a, input int b, input int c, input int d);
    int m = 0;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic run_small(input vec_t v, input string nm);
    int cyc = 0;
    bit got = 0;
    mem_s[0] = v.a; mem_s[1] = v.b; mem_s[2] = v.c; mem_s[3] = v.d;
    @(negedge clk) s_start = 1'b1;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      s_start = 1'b0;
      cyc++;
      if (s_wr_en) got = 1;
    end
    check({nm, "_latency"}, cyc, 6);
    check({nm, "_addr"}, s_wr_addr, 0);
    check({nm, "_data"}, s_wr_data, v.exp);
    @(negedge clk);
    check({nm, "_done"}, {s_done, s_busy}, 2'b10);
  endtask

  task automatic tick_d();
    @(negedge clk);
    dcyc++;
    if (d_wr_en) begin wa.push_back(d_wr_addr); wd.push_back(d_wr_data); end
    if (d_rd_en) ra.push_back(d_rd_addr);
    if (d_rd_en && d_wr_en) ovl++;
  endtask

  initial begin
    int n, done_cyc, busy_at_done, e_addr, e_data, e_rd, k, cyc;
    int offs[4];
    vec_t rv;
    tv[0] = '{a: -3,   b: 7,    c: 5,   d: -1, exp: 7};
    tv[1] = '{a: -128, b: -1,   c: -50, d: -2, exp: 0};
    tv[2] = '{a: 127,  b: -128, c: 0,   d: 0,  exp: 127};
    offs[0] = 0; offs[1] = 1; offs[2] = 32; offs[3] = 33;
    for (int i = 0; i < 32768; i++) mem_d[i] = 8'(i % 256);

    repeat (3) @(negedge clk);
    check("rst_ctrl", {d_busy, d_done, d_rd_en, d_wr_en, s_busy, s_done, s_rd_en, s_wr_en}, 0);
    check("rst_rd_addr", d_rd_addr, 0);
    check("rst_wr_addr", d_wr_addr, 0);
    check("rst_wr_data", d_wr_data, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 3; i++) run_small(tv[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 20; i++) begin
      rv.a = 8'($urandom); rv.b = 8'($urandom); rv.c = 8'($urandom); rv.d = 8'($urandom);
      rv.exp = relu_max4(rv.a, rv.b, rv.c, rv.d);
      run_small(rv, $sformatf("rnd%0d", i));
    end

    mem_s[0] = 8'sd9; mem_s[1] = -8'sd4; mem_s[2] = 8'sd3; mem_s[3] = 8'sd1;
    @(negedge clk) s_start = 1'b1;
    cyc = 0;
    while (cyc < 20 && !s_done) begin @(negedge clk); cyc++; end
    check("b2b_first_done", s_done, 1);
    @(negedge clk);
    check("b2b_done_pulse", s_done, 0);
    check("b2b_restart_rd", {s_rd_en, s_rd_addr}, 3'b100);
    s_start = 1'b0;
    cyc = 0;
    while (cyc < 20 && !s_wr_en) begin @(negedge clk); cyc++; end
    check("b2b_second_addr", s_wr_addr, 0);
    check("b2b_second_data", s_wr_data, 9);

    wa.delete(); wd.delete(); ra.delete(); dcyc = 0; ovl = 0;
    d_start = 1'b1;
    repeat (500) begin tick_d(); d_start = 1'b0; end
    check("pre_rst_busy", d_busy, 1);
    check("pre_rst_writes", wa.size(), 83);
    rst = 1'b1;
    #1;
    check("abort_outputs", {d_rd_en, d_wr_en, d_busy, d_done}, 0);
    check("abort_rd_addr", d_rd_addr, 0);
    n = wa.size();
    repeat (3) tick_d();
    rst = 1'b0;
    repeat (4) tick_d();
    check("abort_no_write", wa.size() - n, 0);

    wa.delete(); wd.delete(); ra.delete(); dcyc = 0; ovl = 0;
    done_cyc = -1; busy_at_done = -1;
    d_start = 1'b1;
    while (dcyc < 45000 && done_cyc < 0) begin
      tick_d();
      d_start = (dcyc == 99 || dcyc == 39999);
      if (d_done) begin done_cyc = dcyc; busy_at_done = d_busy; end
    end
    check("done_cycle", done_cyc, 43009);
    check("busy_at_done", busy_at_done, 0);
    check("write_count", wa.size(), 7168);
    check("read_count", ra.size(), 28672);
    check("rd_wr_overlap", ovl, 0);
    if (ra.size() >= 900) begin
      check("rd_first_0", ra[0], 0);
      check("rd_first_1", ra[1], 1);
      check("rd_first_2", ra[2], 32);
      check("rd_first_3", ra[3], 33);
      check("rd_ch1_0", ra[896], 896);
      check("rd_ch1_1", ra[897], 897);
      check("rd_ch1_2", ra[898], 928);
      check("rd_ch1_3", ra[899], 929);
    end
    e_addr = 0; e_data = 0; e_rd = 0; k = 0;
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 14; r++)
        for (int col = 0; col < 16; col++) begin
          int base;
          base = c * 896 + 2 * r * 32 + 2 * col;
          if (k < wa.size()) begin
            if (wa[k] != k) e_addr++;
            if (wd[k] != relu_max4(mem_d[base], mem_d[base + 1], mem_d[base + 32], mem_d[base + 33])) e_data++;
          end
          for (int j = 0; j < 4; j++)
            if (4 * k + j < ra.size() && ra[4 * k + j] != base + offs[j]) e_rd++;
          k++;
        end
    check("wr_addr_sequence_errors", e_addr, 0);
    check("wr_data_model_errors", e_data, 0);
    check("rd_addr_sequence_errors", e_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/relu_maxpool.md
# relu_maxpool

Post-normalization stage that consumes the int8 feature maps written by the batch-norm stage into its output BRAM (CHANNELS×HEIGHT×WIDTH, channel-major, row-major). For every 2×2 window at stride 2, it computes the maximum of the four samples and clamps the result to zero or above (ReLU). Results are written sequentially into a pooled-output BRAM that feeds the next convolution layer. The block is a start/done controlled engine that drives the read port of the upstream BRAM and the write port of the downstream BRAM.

## Interface
- DATA_WIDTH, 8: signed sample width.
- CHANNELS, 32: number of feature-map channels.
- HEIGHT, 28: input rows per channel; must be even.
- WIDTH, 32: input columns per channel; must be even.
- IN_ADDR_W, 15: input BRAM address width; must satisfy 2^IN_ADDR_W ≥ CHANNELS·HEIGHT·WIDTH.
- OUT_ADDR_W, 13: output BRAM address width; must satisfy 2^OUT_ADDR_W ≥ CHANNELS·HEIGHT·WIDTH/4.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled run request; honoured only in IDLE or DONE.
- busy  out  1  high from the first cycle after start is accepted until the final write.
- done  out  1  high while in DONE; cleared when a new start is accepted.
- rd_en  out  1  input BRAM enable.
- rd_addr  out  IN_ADDR_W  input BRAM address.
- rd_data  in  DATA_WIDTH  signed input BRAM data, valid 1 cycle after rd_en.
- wr_en  out  1  output BRAM write strobe; enable and write-enable are tied together.
- wr_addr  out  OUT_ADDR_W  output BRAM address.
- wr_data  out  DATA_WIDTH  pooled value; always ≥ 0.

## Operation
- States: IDLE → RD0 → RD1 → RD2 → RD3 → LAST → WR → (RD0 | DONE). From DONE, start returns to RD0.
- Counters:
  - ch runs 0..CHANNELS-1.
  - orow runs 0..HEIGHT/2-1.
  - ocol runs 0..WIDTH/2-1.
  - out_addr runs 0..CHANNELS·HEIGHT·WIDTH/4-1.
- Window base = ch·HEIGHT·WIDTH + 2·orow·WIDTH + 2·ocol.
- Taps RD0..RD3 drive rd_en=1 with rd_addr = base, base+1, base+WIDTH, base+WIDTH+1, in that order.
- Accumulator acc (signed, DATA_WIDTH):
  - Set to 0 on entry to RD0. The zero seed implements ReLU.
  - In RD1, RD2, RD3 and LAST: acc ← max(acc, rd_data), using a signed compare.
- WR: wr_en=1, wr_data=acc, wr_addr=out_addr. In the same cycle, out_addr increments and ocol/orow/ch advance in that order with wrap to 0.
- After the write with ch=CHANNELS-1, orow=HEIGHT/2-1, ocol=WIDTH/2-1 → DONE. All counters return to 0.
- start while busy is ignored.
- rd_en and wr_en are never high in the same cycle.
- No arithmetic overflow is possible: the output range is 0..2^(DATA_WIDTH-1)-1.

## Timing
- Reset (async assert): state IDLE, all counters 0, acc 0, busy 0, done 0, rd_en 0, rd_addr 0, wr_en 0, wr_addr 0, wr_data 0.
- Reset deassertion is synchronised internally (2-flop) before the FSM leaves IDLE.
- All outputs are registered.
- start sampled high in cycle T (IDLE/DONE) → RD0 in T+1 with rd_en=1, busy=1, done=0.
- Each output pixel takes exactly 6 cycles (RD0..WR). The first wr_en appears at T+6.
- Total run = 6·CHANNELS·HEIGHT·WIDTH/4 cycles. With defaults this is 43008; the last wr_en is at T+43008 and done=1 / busy=0 at T+43009.
- Reset asserted mid-run aborts immediately: no further reads or writes, and outputs take their reset values. Output BRAM contents already written are left as-is.
- start held high continuously: a new run begins in the cycle after DONE is entered. done is then high for exactly 1 cycle.

## Test plan
- Single window, CHANNELS=1, HEIGHT=2, WIDTH=2, input {-3, 7, 5, -1} → one write: wr_addr 0, wr_data 7, 6 cycles after start.
- All-negative window {-128, -1, -50, -2} → wr_data 0. Window {127, -128, 0, 0} → wr_data 127.
- Default parameters, input[i] = (i mod 256) as signed:
  - Exactly 7168 writes, wr_addr 0..7167 strictly sequential.
  - wr_data matches the reference model for each window.
  - The first window reads addresses 0, 1, 32, 33. Channel 1's first window reads 896, 897, 928, 929.
  - done rises 43009 cycles after start.
- start pulsed again during a run (at cycles T+100 and T+40000) → no effect on the address or data sequence, and the write count stays 7168.
- rst asserted at T+500 for 3 cycles → rd_en, wr_en and busy drop in the same cycle and no write follows. A subsequent start replays from wr_addr 0 with identical data.
- Back-to-back runs with start held high → done pulses for 1 cycle, and the second run's first read is rd_addr 0.
